// File: rtl/vdp_bus_pkg.sv
// Shared definitions for the CPU-to-VDP bus bridge.
//
// Contents:
//   FIFO_DEPTH_MIN / FIFO_DEPTH_MAX : legal range for the write-queue depth
//                                     (the depth must also be a power of two)
//   issue_state_t                   : states of the request-issue FSM
package vdp_bus_pkg;

    localparam int FIFO_DEPTH_MIN = 2;
    localparam int FIFO_DEPTH_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/cpu_bus_bridge_strobe_filter.sv
// Synchroniser and glitch filter for one active-low CPU strobe.
//
// Ports:
//   clk          : block clock
//   reset        : asynchronous active-high reset
//   strobe_n_raw : raw asynchronous strobe, active low
//   fall         : one-cycle pulse, registered in the same cycle the filtered
//                  strobe drops from 1 to 0
//
// The raw strobe passes through two flops. The filtered level only follows the
// synchronised level after FILTER_LEN consecutive disagreeing samples, and any
// agreeing sample restarts the count.
module strobe_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_n_raw,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             strobe_n_filt;
    logic [CNT_W-1:0] agree_cnt;

    // The synchroniser flops reset to the idle (high) level so that leaving
    // reset never looks like a strobe edge. The fall pulse is raised on the
    // same edge that commits the new low filtered level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1       <= 1'b1;
            sync_q2       <= 1'b1;
            strobe_n_filt <= 1'b1;
            agree_cnt     <= '0;
            fall          <= 1'b0;
        end else begin
            sync_q1 <= strobe_n_raw;
            sync_q2 <= sync_q1;
            fall    <= 1'b0;
            if (sync_q2 != strobe_n_filt) begin
                if (agree_cnt == CNT_LAST) begin
                    strobe_n_filt <= sync_q2;
                    agree_cnt     <= '0;
                    fall          <= ~sync_q2;
                end else begin
                    agree_cnt <= agree_cnt + 1'b1;
                end
            end else begin
                agree_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_bus_bridge.sv
// Bridge from an asynchronous CPU strobe bus to the VDP request/acknowledge bus.
//
// Ports:
//   clk, reset          : block clock, asynchronous active-high reset
//   csr_n, csw_n        : raw CPU read / write strobes, active low
//   mode, cd_in         : raw CPU port-select and data bus
//   req, wrt, adr, dbo  : VDP request, write qualifier, port address, data
//   ack                 : VDP acknowledge
//   clr_err             : clears the sticky overflow/conflict flags
//   fifo_level          : number of writes waiting in the queue
//   overflow, conflict  : sticky error flags
//
// CPU writes are queued in a small FIFO; a CPU read sets a single pending flag.
// The issue FSM always drains queued writes before serving a pending read, so a
// read can never overtake a write that was queued before it.
module cpu_bus_bridge
    import vdp_bus_pkg::*;
#(
    parameter int ADDR_W     = 2,
    parameter int FILTER_LEN = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          csr_n,
    input  logic                          csw_n,
    input  logic [ADDR_W-1:0]             mode,
    input  logic [7:0]                    cd_in,
    output logic                          req,
    output logic                          wrt,
    output logic [ADDR_W-1:0]             adr,
    output logic [7:0]                    dbo,
    input  logic                          ack,
    input  logic                          clr_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          conflict
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 8;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0] mode_s1, mode_s2;
    logic [7:0]        cd_s1, cd_s2;
    logic              rd_fall, wr_fall;
    logic              rd_event, wr_event, both_event;
    logic              push_ok, pop;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [ENT_W-1:0]  head;
    logic              rd_pending, rd_done;
    logic [ADDR_W-1:0] rd_adr;

    issue_state_t      state, state_n;
    logic              req_n, wrt_n;
    logic [ADDR_W-1:0] adr_n;
    logic [7:0]        dbo_n;

    strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_rd_filter (
        .clk          (clk),
        .reset        (reset),
        .strobe_n_raw (csr_n),
        .fall         (rd_fall)
    );

    strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_wr_filter (
        .clk          (clk),
        .reset        (reset),
        .strobe_n_raw (csw_n),
        .fall         (wr_fall)
    );

    // Port-select and data only need plain two-flop synchronisation; the CPU
    // holds them stable for the whole strobe, well beyond the filter delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_s1 <= '0;
            mode_s2 <= '0;
            cd_s1   <= '0;
            cd_s2   <= '0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            cd_s1   <= cd_in;
            cd_s2   <= cd_s1;
        end
    end

    // Coincident read and write edges are ambiguous, so both are discarded and
    // only the conflict flag records them.
    always_comb begin
        both_event = rd_fall & wr_fall;
        rd_event   = rd_fall & ~wr_fall;
        wr_event   = wr_fall & ~rd_fall;
        push_ok    = wr_event && (level != LVL_FULL);
        head       = mem[rd_ptr];
    end

    // Queue storage carries no reset: emptiness is tracked by the pointers and
    // level alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {mode_s2, cd_s2};
        end
    end

    // Pointers wrap naturally because the depth is a power of two. A push to a
    // full queue is dropped even if a pop happens in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Only one read can be outstanding; further read edges while one is
    // pending are merged into it and keep the first address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_adr     <= '0;
        end else if (rd_event && !rd_pending) begin
            rd_pending <= 1'b1;
            rd_adr     <= mode_s2;
        end else if (rd_done) begin
            rd_pending <= 1'b0;
        end
    end

    // Sticky error flags: a new error in the same cycle as a clear survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            conflict <= 1'b0;
        end else begin
            overflow <= (wr_event && (level == LVL_FULL)) | (overflow & ~clr_err);
            conflict <= both_event | (conflict & ~clr_err);
        end
    end

    // Issue FSM next-state and next-output logic. Bus outputs are registered
    // and hold their values while waiting for ack. Returning through IDLE after
    // every ack gives the one-cycle gap between requests. Queued writes take
    // priority over a pending read.
    always_comb begin
        state_n = state;
        req_n   = req;
        wrt_n   = wrt;
        adr_n   = adr;
        dbo_n   = dbo;
        pop     = 1'b0;
        rd_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    adr_n   = head[ENT_W-1:8];
                    dbo_n   = head[7:0];
                    wrt_n   = 1'b1;
                    req_n   = 1'b1;
                    state_n = ST_WRITE;
                end else if (rd_pending) begin
                    adr_n   = rd_adr;
                    wrt_n   = 1'b0;
                    req_n   = 1'b1;
                    state_n = ST_READ;
                end
            end
            ST_WRITE: begin
                if (ack) begin
                    req_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            ST_READ: begin
                if (ack) begin
                    req_n   = 1'b0;
                    rd_done = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Issue FSM state and output registers; reset abandons any request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            req   <= 1'b0;
            wrt   <= 1'b0;
            adr   <= '0;
            dbo   <= '0;
        end else begin
            state <= state_n;
            req   <= req_n;
            wrt   <= wrt_n;
            adr   <= adr_n;
            dbo   <= dbo_n;
        end
    end

    assign fifo_level = level;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed testbench for cpu_bus_bridge with default parameters
// (ADDR_W=2, FILTER_LEN=3, FIFO_DEPTH=4).
module tb_cpu_bus_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic       csr_n, csw_n;
    logic [1:0] mode;
    logic [7:0] cd_in;
    logic       req, wrt;
    logic [1:0] adr;
    logic [7:0] dbo;
    logic       ack, clr_err;
    logic [2:0] fifo_level;
    logic       overflow, conflict;

    int vectors     = 0;
    int miscompares = 0;

    cpu_bus_bridge #(.ADDR_W(2), .FILTER_LEN(3), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_n      (csr_n),
        .csw_n      (csw_n),
        .mode       (mode),
        .cd_in      (cd_in),
        .req        (req),
        .wrt        (wrt),
        .adr        (adr),
        .dbo        (dbo),
        .ack        (ack),
        .clr_err    (clr_err),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;

    // Advance n clock edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] m, input logic [7:0] d, input int low_cycles);
        mode  = m;
        cd_in = d;
        step(1);
        csw_n = 1'b0;
        step(low_cycles);
        csw_n = 1'b1;
        step(6);
    endtask

    task automatic cpu_read(input logic [1:0] m, input int low_cycles);
        mode = m;
        step(1);
        csr_n = 1'b0;
        step(low_cycles);
        csr_n = 1'b1;
        step(6);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (req === 1'b1) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; csr_n = 1'b1; csw_n = 1'b1; mode = 2'd0; cd_in = 8'h00;
        ack = 1'b0; clr_err = 1'b0;
        step(3);
        vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b expected 0", req); end
        vectors++; if (wrt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wrt: got %b expected 0", wrt); end
        vectors++; if (adr !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_adr: got %0d expected 0", adr); end
        vectors++; if (dbo !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_dbo: got %h expected 00", dbo); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        vectors++; if (conflict !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_conflict: got %b expected 0", conflict); end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        mode = 2'd1; cd_in = 8'hA5;
        step(1);
        csw_n = 1'b0;
        step(2);
        csw_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (req !== 1'b0 || fifo_level !== 3'd0) seen = 1'b1;
            step(1);
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_no_push: got activity %b expected 0", seen); end
    endtask

    task automatic test_single_write();
        bit found;
        cpu_write(2'd1, 8'h5A, 8);
        wait_req(20, found);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("[TB] FAIL single_req: got %b expected 1", found); end
        vectors++; if (adr !== 2'd1) begin miscompares++; $display("[TB] FAIL single_adr: got %0d expected 1", adr); end
        vectors++; if (dbo !== 8'h5A) begin miscompares++; $display("[TB] FAIL single_dbo: got %h expected 5a", dbo); end
        vectors++; if (wrt !== 1'b1) begin miscompares++; $display("[TB] FAIL single_wrt: got %b expected 1", wrt); end
        step(3);
        vectors++; if (req !== 1'b1 || dbo !== 8'h5A) begin miscompares++; $display("[TB] FAIL single_hold: got req=%b dbo=%h expected req=1 dbo=5a", req, dbo); end
        ack_pulse();
        vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL single_drop: got %b expected 0", req); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL single_level: got %0d expected 0", fifo_level); end
        step(5);
    endtask

    task automatic test_fifo_overflow();
        bit found;
        logic [7:0] exp_data;
        for (int k = 1; k <= 5; k++) cpu_write(2'd2, 8'(k), 6);
        vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("[TB] FAIL ovf_level_full: got %0d expected 4", fifo_level); end
        vectors++; if (req !== 1'b1 || dbo !== 8'h01) begin miscompares++; $display("[TB] FAIL ovf_head_in_flight: got req=%b dbo=%h expected req=1 dbo=01", req, dbo); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_not_yet: got %b expected 0", overflow); end
        cpu_write(2'd2, 8'h06, 6);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
        vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("[TB] FAIL ovf_level_kept: got %0d expected 4", fifo_level); end
        for (int k = 1; k <= 5; k++) begin
            exp_data = 8'(k);
            wait_req(5, found);
            vectors++; if (found !== 1'b1 || dbo !== exp_data || wrt !== 1'b1 || adr !== 2'd2) begin
                miscompares++;
                $display("[TB] FAIL drain_%0d: got req=%b wrt=%b adr=%0d dbo=%h expected req=1 wrt=1 adr=2 dbo=%h", k, found, wrt, adr, dbo, exp_data);
            end
            ack_pulse();
            vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_gap_%0d: got %b expected 0", k, req); end
        end
        step(6);
        vectors++; if (req !== 1'b0 || fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL drain_empty: got req=%b level=%0d expected req=0 level=0", req, fifo_level); end
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_read_after_write();
        bit found;
        bit seen = 1'b0;
        cpu_write(2'd0, 8'h11, 6);
        wait_req(10, found);
        vectors++; if (found !== 1'b1 || wrt !== 1'b1 || dbo !== 8'h11) begin miscompares++; $display("[TB] FAIL raw_write: got req=%b wrt=%b dbo=%h expected 1 1 11", found, wrt, dbo); end
        cpu_read(2'd3, 6);
        vectors++; if (req !== 1'b1 || wrt !== 1'b1 || dbo !== 8'h11) begin miscompares++; $display("[TB] FAIL raw_order: got req=%b wrt=%b dbo=%h expected 1 1 11", req, wrt, dbo); end
        ack_pulse();
        vectors++; if (req !== 1'b0) begin miscompares++; $display("[TB] FAIL raw_gap: got %b expected 0", req); end
        step(1);
        vectors++; if (req !== 1'b1 || wrt !== 1'b0 || adr !== 2'd3) begin miscompares++; $display("[TB] FAIL raw_read: got req=%b wrt=%b adr=%0d expected 1 0 3", req, wrt, adr); end
        ack_pulse();
        for (int i = 0; i < 12; i++) begin
            if (req !== 1'b0) seen = 1'b1;
            step(1);
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL raw_read_done: got extra req %b expected 0", seen); end
    endtask

    task automatic test_conflict();
        bit seen = 1'b0;
        mode = 2'd1; cd_in = 8'h33;
        step(1);
        csr_n = 1'b0; csw_n = 1'b0;
        step(6);
        csr_n = 1'b1; csw_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (req !== 1'b0) seen = 1'b1;
            step(1);
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_no_req: got %b expected 0", seen); end
        vectors++; if (conflict !== 1'b1) begin miscompares++; $display("[TB] FAIL conflict_set: got %b expected 1", conflict); end
        vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL conflict_level: got %0d expected 0", fifo_level); end
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        vectors++; if (conflict !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_clear: got %b expected 0", conflict); end
    endtask

    task automatic test_reset_mid_request();
        bit seen = 1'b0;
        for (int k = 0; k < 4; k++) cpu_write(2'd1, 8'hC0 + 8'(k), 6);
        vectors++; if (req !== 1'b1 || fifo_level !== 3'd3) begin miscompares++; $display("[TB] FAIL midrst_setup: got req=%b level=%0d expected 1 3", req, fifo_level); end
        reset = 1'b1;
        step(1);
        vectors++; if (req !== 1'b0 || fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL midrst_abandon: got req=%b level=%0d expected 0 0", req, fifo_level); end
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (req !== 1'b0) seen = 1'b1;
            step(1);
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_quiet: got req %b expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_write();
        test_fifo_overflow();
        test_read_after_write();
        test_conflict();
        test_reset_mid_request();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
